// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: interrupt-source, pipeline handshake and Status update signals for intr_ctrl.
interface intr_ctrl_if;
    logic [3:0]  intr_src;
    logic [31:0] status_in;
    logic        intr_ack;
    logic        eret;
    logic        intr_req;
    logic [1:0]  intr_vec;
    logic [31:0] intr_addr;
    logic [31:0] sta_data;
    logic        sta_write;
    logic [3:0]  pending;
    modport master (
        input  intr_src, status_in, intr_ack, eret,
        output intr_req, intr_vec, intr_addr, sta_data, sta_write, pending
    );
    modport slave (
        output intr_src, status_in, intr_ack, eret,
        input  intr_req, intr_vec, intr_addr, sta_data, sta_write, pending
    );
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: 4-source edge-triggered interrupt controller driving the Status register on entry/eret.
// Define INTR_SYNC_EN to pass intr_src through a 2-flop synchronizer before edge detection.
module intr_ctrl #(
    parameter logic [31:0] VEC_BASE   = 32'h0000_0800,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0010
) (
    input logic         clk,
    input logic         rst,
    intr_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, REQ, ENTER, LEAVE} state_t;
    state_t     state, state_nx;
    logic [3:0] src_in, src_q, pending, elig, m, s, s_clr, blk, clr;
    logic [1:0] vec, winner;
    logic       eret_pend;
    assign m = bus.status_in[3:0];
    assign s = bus.status_in[7:4];
`ifdef INTR_SYNC_EN
    logic [3:0] sync1, sync2;
    always_ff @(posedge clk or negedge rst)
        if (!rst) {sync2, sync1} <= '0;
        else {sync2, sync1} <= {sync1, bus.intr_src};
    assign src_in = sync2;
`else
    assign src_in = bus.intr_src;
`endif
    // a source is blocked by any in-service source of equal or higher priority
    assign blk    = {|s[3:0], |s[2:0], |s[1:0], s[0]};
    assign elig   = pending & m & ~blk;
    assign winner = elig[0] ? 2'd0 : elig[1] ? 2'd1 : elig[2] ? 2'd2 : 2'd3;
    assign s_clr  = s & (s - 4'd1);
    assign clr    = (state == ENTER) ? 4'b0001 << vec : 4'b0000;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state     <= IDLE;
            vec       <= '0;
            src_q     <= '0;
            pending   <= '0;
            eret_pend <= 1'b0;
        end else begin
            state     <= state_nx;
            src_q     <= src_in;
            pending   <= (pending & ~clr) | (src_in & ~src_q);
            eret_pend <= bus.eret | (eret_pend & (state != LEAVE));
            if (state == IDLE && !eret_pend && |elig) vec <= winner;
        end
    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = eret_pend ? LEAVE : (|elig) ? REQ : IDLE;
            REQ:     state_nx = bus.intr_ack ? ENTER : !elig[vec] ? IDLE : REQ;
            default: state_nx = IDLE;
        endcase
    end
    assign bus.intr_req  = state == REQ;
    assign bus.intr_vec  = vec;
    assign bus.intr_addr = VEC_BASE + VEC_STRIDE * {30'd0, vec};
    assign bus.sta_write = (state == ENTER) || (state == LEAVE);
    assign bus.sta_data  = (state == ENTER) ? bus.status_in | (32'd16 << vec) :
                           (state == LEAVE) ? {bus.status_in[31:8], s_clr, bus.status_in[3:0]} : 32'd0;
    assign bus.pending   = pending;
endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl: randomized scoreboard bench for intr_ctrl against a rule-level reference model.
module tb_intr_ctrl;
    localparam logic [31:0] BASE = 32'h0000_0800, STRIDE = 32'h0000_0010;
    logic clk = 1'b0, rst = 1'b0;
    always #5 clk = ~clk;
    intr_ctrl_if bus();
    intr_ctrl #(.VEC_BASE(BASE), .VEC_STRIDE(STRIDE)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {bit [3:0] pend; bit req; bit [1:0] vec;} obs_t;
    obs_t      obs_q[$];
    bit [31:0] sw_q[$];
    bit [3:0]  m_pend, m_prev, m_s1, m_s2;
    bit        m_eret, run;
    int        m_req = -1, m_wr = 0, m_vec = 0;
    int        n_vec = 0, n_bad = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic bad(string name);
        n_vec++;
        n_bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic bit can_take(int i, bit [31:0] st);
        if (!m_pend[i] || !st[i]) return 0;
        for (int j = 0; j <= i; j++) if (st[4+j]) return 0;
        return 1;
    endfunction
    function automatic int pick(bit [31:0] st);
        for (int i = 0; i < 4; i++) if (can_take(i, st)) return i;
        return -1;
    endfunction
    function automatic bit [31:0] leave_data(bit [31:0] st);
        for (int i = 0; i < 4; i++) if (st[4+i]) begin st[4+i] = 1'b0; return st; end
        return st;
    endfunction

    // advance the model across the coming clock edge using this cycle's inputs
    task automatic step(bit [3:0] src, bit [31:0] st, bit ack, bit er);
        bit [3:0] seen, rise;
        bit was_enter = (m_wr == 1), had_eret = m_eret;
        int w = pick(st);
`ifdef INTR_SYNC_EN
        seen = m_s2; m_s2 = m_s1; m_s1 = src;
`else
        seen = src;
`endif
        rise = seen & ~m_prev;
        m_prev = seen;
        m_eret = er || (m_eret && m_wr != 2);
        if (m_wr != 0) m_wr = 0;
        else if (m_req >= 0) begin
            if (ack) begin m_wr = 1; m_req = -1; end
            else if (!can_take(m_req, st)) m_req = -1;
        end else if (had_eret) m_wr = 2;
        else if (w >= 0) begin m_req = w; m_vec = w; end
        if (was_enter) m_pend[m_vec] = 1'b0;
        m_pend |= rise;
    endtask

    task automatic cycle(bit [3:0] src, bit [31:0] st, bit ack, bit er);
        @(negedge clk);
        bus.intr_src = src; bus.status_in = st; bus.intr_ack = ack; bus.eret = er;
        obs_q.push_back('{m_pend, m_req >= 0, 2'(m_vec)});
        if (m_wr == 1) sw_q.push_back(st | (32'd1 << (4 + m_vec)));
        if (m_wr == 2) sw_q.push_back(leave_data(st));
        step(src, st, ack, er);
    endtask
    task automatic idle(int n, bit [3:0] src, bit [31:0] st);
        repeat (n) cycle(src, st, 1'b0, 1'b0);
    endtask

    task automatic reset_mid();
        @(negedge clk);
        #3 rst = 1'b0;
        #1;
        chk("rst_intr_req", bus.intr_req, 0);
        chk("rst_pending", bus.pending, 0);
        chk("rst_sta_write", bus.sta_write, 0);
        chk("rst_intr_addr", bus.intr_addr, BASE);
        m_pend = 0; m_prev = 0; m_s1 = 0; m_s2 = 0; m_eret = 0; m_req = -1; m_wr = 0; m_vec = 0;
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    initial begin
        obs_t e;
        forever begin
            @(negedge clk);
            #1;
            if (run && obs_q.size() > 0) begin
                e = obs_q.pop_front();
                chk("pending", bus.pending, e.pend);
                chk("intr_req", bus.intr_req, e.req);
                if (e.req) begin
                    chk("intr_vec", bus.intr_vec, e.vec);
                    chk("intr_addr", bus.intr_addr, BASE + e.vec * STRIDE);
                end
                if (bus.sta_write) begin
                    if (sw_q.size() == 0) bad("unexpected_sta_write");
                    else chk("sta_data", bus.sta_data, sw_q.pop_front());
                end else if (sw_q.size() > 0) begin
                    bad("missing_sta_write");
                    void'(sw_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit [31:0] st;
        bit [3:0]  src;
        bus.intr_src = 0; bus.status_in = 32'h0F; bus.intr_ack = 0; bus.eret = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_intr_req", bus.intr_req, 0);
        chk("reset_intr_vec", bus.intr_vec, 0);
        chk("reset_intr_addr", bus.intr_addr, 32'h800);
        chk("reset_sta_write", bus.sta_write, 0);
        chk("reset_sta_data", bus.sta_data, 0);
        chk("reset_pending", bus.pending, 0);
        rst = 1'b1;
        run = 1'b1;
        idle(2, 4'b0000, 32'h0F);
        idle(3, 4'b0100, 32'h0F);
        cycle(4'b0100, 32'h0F, 1'b1, 1'b0);
        idle(2, 4'b0100, 32'h0F);
        idle(2, 4'b0000, 32'h4F);
        idle(4, 4'b1010, 32'h4F);
        cycle(4'b1010, 32'h4F, 1'b1, 1'b0);
        idle(2, 4'b1010, 32'h4F);
        idle(4, 4'b0000, 32'h6F);
        cycle(4'b0000, 32'h6F, 1'b0, 1'b1);
        idle(3, 4'b0000, 32'h6F);
        idle(2, 4'b0000, 32'h4F);
        cycle(4'b0000, 32'h4F, 1'b0, 1'b1);
        idle(3, 4'b0000, 32'h4F);
        idle(3, 4'b0000, 32'h0F);
        cycle(4'b0000, 32'h0F, 1'b1, 1'b0);
        idle(2, 4'b0000, 32'h0F);
        idle(2, 4'b0000, 32'h8F);
        cycle(4'b0000, 32'h8F, 1'b0, 1'b1);
        idle(3, 4'b0000, 32'h8F);
        idle(3, 4'b0100, 32'h0B);
        idle(3, 4'b0100, 32'h0F);
        idle(3, 4'b0100, 32'h0B);
        idle(2, 4'b0100, 32'h0F);
        cycle(4'b0100, 32'h0F, 1'b0, 1'b1);
        cycle(4'b0100, 32'h0F, 1'b1, 1'b0);
        idle(4, 4'b0100, 32'h0F);
        idle(1, 4'b0000, 32'h0F);
        idle(3, 4'b0001, 32'h0F);
        reset_mid();
        st = 32'h0F;
        src = 4'b0000;
        repeat (3000) begin
            if ($urandom_range(9) == 0) begin
                st[31:8] = 24'($urandom());
                st[7:4]  = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom_range(15));
                st[3:0]  = ($urandom_range(3) != 0) ? 4'hF : 4'($urandom_range(15));
            end
            if ($urandom_range(3) == 0) src = 4'($urandom_range(15));
            cycle(src, st, $urandom_range(2) == 0, $urandom_range(19) == 0);
        end
        idle(4, src, st);
        @(negedge clk);
        #2;
        chk("obs_queue_drained", obs_q.size(), 0);
        chk("sta_queue_drained", sw_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
